// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared FSM encoding and parameter defaults for the interrupt controller.
package int_ctrl_pkg;
    typedef enum logic {IDLE, ASSERT} state_t;
    localparam int DEF_NUM_IRQ   = 5;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_VEC_BASE  = 'hFFF0;
    localparam int DEF_VEC_SHIFT = 1;
endpackage

// File: rtl/int_ctrl_prio_enc.sv
// prio_enc: lowest-index-set-bit encoder with valid flag.
//   req   in  N   request vector, bit 0 highest priority
//   valid out 1   any request bit set
//   idx   out W   index of lowest set bit (0 when none)
module prio_enc #(
    parameter int N = 5,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);
    always_comb begin
        valid = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
    end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: prioritised, nestable interrupt controller with vectored requests.
//   clk, rst     clock, asynchronous active-high reset
//   irq_in       asynchronous interrupt lines, rising edge requests service
//   int_en       global interrupt enable
//   mask_wr/in   mask register load (1 = masked)
//   irq_ack      control unit accepts the presented request
//   eoi          end of interrupt, retires the highest-priority in-service channel
//   irq_req      request to the control unit
//   irq_no       requested channel, vec_addr its vector address
//   mask_out     mask register, in_service in-service register
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ   = DEF_NUM_IRQ,
    parameter int                 ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  VEC_BASE  = ADDR_W'(DEF_VEC_BASE),
    parameter int                 VEC_SHIFT = DEF_VEC_SHIFT,
    localparam int                W         = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_en,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [W-1:0]       irq_no,
    output logic [ADDR_W-1:0]  vec_addr,
    output logic [NUM_IRQ-1:0] mask_out,
    output logic [NUM_IRQ-1:0] in_service
);
    logic [NUM_IRQ-1:0] sync1, sync2, prev, pending, mask, isr;
    logic [NUM_IRQ-1:0] rise, ack_vec, eoi_vec;
    logic               cand_valid, isr_valid, grant, ack;
    logic [W-1:0]       cand_idx, isr_idx, irq_no_n;
    state_t             state, state_n;

    prio_enc #(.N(NUM_IRQ)) u_cand (.req(pending & ~mask), .valid(cand_valid), .idx(cand_idx));
    prio_enc #(.N(NUM_IRQ)) u_isr  (.req(isr),             .valid(isr_valid),  .idx(isr_idx));

    assign rise = sync2 & ~prev;
    // Nesting: only a strictly higher-priority channel may preempt those in service.
    assign grant = int_en & cand_valid & (~isr_valid | (cand_idx < isr_idx));
    assign ack_vec = ack ? NUM_IRQ'(1) << irq_no : '0;
    assign eoi_vec = (eoi & isr_valid) ? NUM_IRQ'(1) << isr_idx : '0;

    always_comb begin
        state_n = state;
        irq_no_n = irq_no;
        ack = 1'b0;
        if (state == IDLE) begin
            if (grant) begin
                state_n = ASSERT;
                irq_no_n = cand_idx;
            end
        end else if (irq_ack) begin
            ack = 1'b1;
            state_n = IDLE;
        end else if (!int_en || mask[irq_no]) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev <= '0;
            pending <= '0;
            mask <= '1;
            isr <= '0;
            state <= IDLE;
            irq_no <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            prev <= sync2;
            // A fresh edge on the acked channel survives the ack.
            pending <= (pending & ~ack_vec) | rise;
            mask <= mask_wr ? mask_in : mask;
            // eoi acts on the pre-ack ISR, then the acked bit is set.
            isr <= (isr & ~eoi_vec) | ack_vec;
            state <= state_n;
            irq_no <= irq_no_n;
        end
    end

    assign irq_req = state == ASSERT;
    assign vec_addr = VEC_BASE + (ADDR_W'(irq_no) << VEC_SHIFT);
    assign mask_out = mask;
    assign in_service = isr;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl (default and 16-channel wrap configurations).
module tb_int_ctrl;
    logic        clk = 1'b0, rst = 1'b1, int_en = 1'b1;
    logic [4:0]  irq_in = '0, mask_in = '0;
    logic        mask_wr = 1'b0, irq_ack = 1'b0, eoi = 1'b0;
    logic        irq_req;
    logic [2:0]  irq_no;
    logic [15:0] vec_addr;
    logic [4:0]  mask_out, in_service;

    logic [15:0] b_irq_in = '0, b_mask_in = '0;
    logic        b_mask_wr = 1'b0, b_irq_ack = 1'b0, b_eoi = 1'b0;
    logic        b_irq_req;
    logic [3:0]  b_irq_no;
    logic [15:0] b_vec_addr, b_mask_out, b_in_service;

    int n_chk = 0, n_fail = 0;

    int_ctrl dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .int_en(int_en), .mask_wr(mask_wr),
        .mask_in(mask_in), .irq_ack(irq_ack), .eoi(eoi), .irq_req(irq_req), .irq_no(irq_no),
        .vec_addr(vec_addr), .mask_out(mask_out), .in_service(in_service)
    );

    int_ctrl #(.NUM_IRQ(16), .ADDR_W(16), .VEC_BASE(16'hFFFF), .VEC_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .irq_in(b_irq_in), .int_en(int_en), .mask_wr(b_mask_wr),
        .mask_in(b_mask_in), .irq_ack(b_irq_ack), .eoi(b_eoi), .irq_req(b_irq_req), .irq_no(b_irq_no),
        .vec_addr(b_vec_addr), .mask_out(b_mask_out), .in_service(b_in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_req", irq_req, 0);
        check("rst_no", irq_no, 0);
        check("rst_vec", vec_addr, 16'hFFF0);
        check("rst_mask", mask_out, 5'b11111);
        check("rst_isr", in_service, 0);
        check("rst_vec_b", b_vec_addr, 16'hFFFF);
        rst = 1'b0;
        mask_wr = 1'b1;
        tick(1);
        mask_wr = 1'b0;
        check("mask_load", mask_out, 0);

        irq_in = 5'b00100;
        tick(3);
        check("lat_e3", irq_req, 0);
        tick(1);
        check("lat_e4", irq_req, 1);
        check("ch2_no", irq_no, 2);
        check("ch2_vec", vec_addr, 16'hFFF4);
        ack_pulse();
        check("ch2_ack_req", irq_req, 0);
        check("ch2_isr", in_service, 5'b00100);
        eoi_pulse();
        check("ch2_eoi", in_service, 0);
        irq_in = '0;
        tick(3);

        irq_in = 5'b01010;
        tick(4);
        check("pair_first", irq_no, 1);
        ack_pulse();
        check("pair_isr1", in_service, 5'b00010);
        tick(2);
        check("pair_blocked", irq_req, 0);
        eoi_pulse();
        tick(1);
        check("pair_req3", irq_req, 1);
        check("pair_no3", irq_no, 3);
        check("pair_vec3", vec_addr, 16'hFFF6);
        ack_pulse();
        check("pair_isr3", in_service, 5'b01000);
        irq_in = '0;
        tick(3);

        irq_in = 5'b00001;
        tick(4);
        check("nest_req", irq_req, 1);
        check("nest_no", irq_no, 0);
        ack_pulse();
        check("nest_isr", in_service, 5'b01001);
        eoi_pulse();
        check("nest_eoi", in_service, 5'b01000);
        irq_in = 5'b00010;
        tick(4);
        check("both_no", irq_no, 1);
        check("both_vec", vec_addr, 16'hFFF2);
        irq_ack = 1'b1;
        eoi = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        eoi = 1'b0;
        check("both_isr", in_service, 5'b00010);
        eoi_pulse();
        check("both_eoi", in_service, 0);
        eoi_pulse();
        check("eoi_empty", in_service, 0);
        irq_in = '0;
        tick(3);

        irq_in = 5'b10000;
        tick(4);
        check("ch4_no", irq_no, 4);
        check("ch4_vec", vec_addr, 16'hFFF8);
        ack_pulse();
        irq_in = '0;
        tick(3);
        irq_in = 5'b10000;
        tick(6);
        check("ch4_same_blocked", irq_req, 0);
        eoi_pulse();
        check("ch4_eoi_isr", in_service, 0);
        tick(1);
        check("ch4_reassert", irq_req, 1);
        check("ch4_reno", irq_no, 4);
        ack_pulse();
        eoi_pulse();
        irq_in = '0;
        tick(3);

        irq_in = 5'b00010;
        tick(4);
        check("mask_pre", irq_req, 1);
        mask_in = 5'b00010;
        mask_wr = 1'b1;
        tick(1);
        mask_wr = 1'b0;
        check("mask_set", mask_out, 5'b00010);
        tick(1);
        check("mask_withdraw", irq_req, 0);
        tick(2);
        check("mask_hold", irq_req, 0);
        mask_in = '0;
        mask_wr = 1'b1;
        tick(1);
        mask_wr = 1'b0;
        tick(1);
        check("unmask_req", irq_req, 1);
        check("unmask_no", irq_no, 1);
        ack_pulse();
        check("unmask_isr", in_service, 5'b00010);
        eoi_pulse();
        irq_in = '0;
        tick(3);

        ack_pulse();
        check("idle_ack_isr", in_service, 0);
        check("idle_ack_req", irq_req, 0);

        int_en = 1'b0;
        irq_in = 5'b00100;
        tick(6);
        check("dis_req", irq_req, 0);
        int_en = 1'b1;
        tick(1);
        check("en_req", irq_req, 1);
        check("en_no", irq_no, 2);
        rst = 1'b1;
        #1;
        check("async_req", irq_req, 0);
        check("async_vec", vec_addr, 16'hFFF0);
        check("async_mask", mask_out, 5'b11111);
        irq_in = '0;
        tick(1);
        rst = 1'b0;
        tick(1);

        b_mask_wr = 1'b1;
        tick(1);
        b_mask_wr = 1'b0;
        b_irq_in = 16'h8000;
        tick(3);
        check("b_e3", b_irq_req, 0);
        tick(1);
        check("b_req", b_irq_req, 1);
        check("b_no", b_irq_no, 15);
        check("b_wrap", b_vec_addr, 16'h000E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 5: number of interrupt channels, 2..16; channel 0 has the highest priority.
REQ-002 Parameter ADDR_W, default 16: width of the vector address.
REQ-003 Parameter VEC_BASE, default 16'hFFF0: vector table base address.
REQ-004 Parameter VEC_SHIFT, default 1: log2 of the byte stride between vector entries.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 irq_in  in  NUM_IRQ  asynchronous interrupt lines; a rising edge requests service.
REQ-009 int_en  in  1  global interrupt enable, driven by the control unit.
REQ-010 mask_wr  in  1  load mask_in into the mask register.
REQ-011 mask_in  in  NUM_IRQ  new mask; 1 = channel masked.
REQ-012 irq_ack  in  1  control unit accepts the request presented on irq_no/vec_addr.
REQ-013 eoi  in  1  end of interrupt, pulsed by the return-from-interrupt microcode.
REQ-014 irq_req  out  1  interrupt request to the control unit.
REQ-015 irq_no  out  clog2(NUM_IRQ)  number of the requested channel.
REQ-016 vec_addr  out  ADDR_W  vector address of the requested channel.
REQ-017 mask_out  out  NUM_IRQ  current mask register.
REQ-018 in_service  out  NUM_IRQ  in-service register (ISR).

Function
REQ-019 Each irq_in bit passes through a two-flop synchronizer followed by one edge-detect flop.
REQ-020 A synchronized rising edge sets pending[i]; levels and falling edges have no effect.
REQ-021 Latency: irq_in is first sampled high at edge E1; pending is set after E3; irq_req is high after E4 when the grant conditions hold.
REQ-022 Candidate: lowest-index i with pending[i] & ~mask[i].
REQ-023 Grant condition: int_en=1, a candidate exists, and its index is lower than every set ISR bit (nesting by priority).
REQ-024 FSM states:
- IDLE: irq_req=0; goes to ASSERT when the grant condition holds, latching irq_no.
- ASSERT: irq_req=1.
REQ-025 irq_no and vec_addr are held stable throughout ASSERT; a higher-priority arrival does not change them.
REQ-026 ASSERT with irq_ack=1:
- clear pending[irq_no];
- set isr[irq_no];
- go to IDLE.
REQ-027 ASSERT with int_en=0 or mask[irq_no]=1 and irq_ack=0: withdraw to IDLE; the pending bit is kept.
REQ-028 irq_ack outside ASSERT is ignored.
REQ-029 eoi clears the lowest-index set ISR bit; eoi with ISR empty is ignored.
REQ-030 eoi and irq_ack in the same cycle: apply eoi to the pre-ack ISR, then set the acked bit.
REQ-031 A new synchronized edge coinciding with irq_ack on the same channel leaves pending set.
REQ-032 vec_addr = VEC_BASE + (irq_no << VEC_SHIFT), truncated to ADDR_W (wraps modulo 2^ADDR_W).
REQ-033 mask_wr takes effect at the next edge; mask changes never clear pending bits.

Reset
REQ-034 rst clears the synchronizers, pending and ISR; the FSM returns to IDLE.
REQ-035 Output reset values: irq_req=0, irq_no=0, vec_addr=VEC_BASE, mask_out=all ones, in_service=0.
REQ-036 rst during ASSERT drops irq_req within the same cycle (asynchronously); the pending request is lost.

Structure
REQ-037 The FSM state encoding and parameter defaults live in the shared CPU include/package alongside the signal definitions.
REQ-038 The priority selection (lowest-index-set-bit encoder with valid flag) is one parametrised sub-module, prio_enc, instantiated twice: once for the candidate and once for the ISR.

Verification
REQ-039 Reset, then mask_in=0, irq_in[2] rises: irq_req=1 after the 4th edge, irq_no=2, vec_addr=16'hFFF4; irq_ack gives in_service=5'b00100.
REQ-040 irq_in[3] and irq_in[1] rise together: channel 1 is presented first; after ack and eoi, channel 3 (vec_addr=16'hFFF6) is presented.
REQ-041 Channel 3 is in service and irq_in[0] rises: the request is granted (nesting), in_service=5'b01001; the first eoi clears bit 0 only.
REQ-042 Channel 4 is in service and irq_in[4] rises again: irq_req stays 0 until eoi, then asserts with irq_no=4.
REQ-043 In ASSERT with irq_no=1, set mask bit 1: irq_req drops and pending[1] is kept; unmasking re-asserts the request.
REQ-044 NUM_IRQ=16, VEC_BASE=16'hFFFF, VEC_SHIFT=0, channel 15 requested: vec_addr=16'h000E (wrap-around).
